// File: rtl/serial_subtractor_ctrl_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Optional zero flag present when SERIAL_SUB_ZERO_FLAG_EN is defined.
interface serial_subtractor_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             zero;

    modport master (output start, a, b, input busy, done, diff, bout, zero);
    modport slave  (input start, a, b, output busy, done, diff, bout, zero);
`else
    modport master (output start, a, b, input busy, done, diff, bout);
    modport slave  (input start, a, b, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor (a - b), one bit per clock, LSB first.
// Define SERIAL_SUB_ZERO_FLAG_EN to add a registered all-zero result flag.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_ctrl_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [WIDTH-1:0] diff_next;
    logic [IW-1:0]    idx_reg;
    logic             br_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             bout_reg;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;

    // Single 1-bit full-subtract cell shared across all bit positions
    assign a_bit   = a_reg[idx_reg];
    assign b_bit   = b_reg[idx_reg];
    assign d_bit   = a_bit ^ b_bit ^ br_reg;
    assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_reg);

    always_comb begin
        diff_next          = diff_reg;
        diff_next[idx_reg] = d_bit;
    end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic zero_reg;
    assign bus.zero = zero_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            diff_reg  <= '0;
            idx_reg   <= '0;
            br_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            bout_reg  <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        br_reg    <= 1'b0;
                        idx_reg   <= '0;
                        diff_reg  <= '0;
                        bout_reg  <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                        zero_reg  <= 1'b0;
`endif
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    diff_reg <= diff_next;
                    br_reg   <= br_next;
                    if (idx_reg == LAST_IDX) begin
                        // Last bit: publish the borrow out and hand over to DONE
                        bout_reg  <= br_next;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                        zero_reg  <= (diff_next == '0);
`endif
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.diff = diff_reg;
    assign bus.bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Randomised self-checking bench for serial_subtractor_ctrl (WIDTH=8 and WIDTH=1 instances).
// Reference results come from plain modular arithmetic on the captured operands.
module tb_serial_subtractor_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_ctrl_if #(.WIDTH(W)) bus  ();
    serial_subtractor_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one operation and report what was observed; no judging here.
    // lat = number of falling edges after the accept edge until done is seen (-1 on timeout).
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] d, output logic bo,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        lat       = -1;
        busy_cnt  = 0;
        for (int c = 0; c < W + 6; c++) begin
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        d  = bus.diff;
        bo = bus.bout;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        #2;
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.bout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b, want all 0",
                     bus.busy, bus.done, bus.diff, bus.bout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.bout} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b diff=%h bout=%b, want all 0",
                     bus.busy, bus.done, bus.diff, bus.bout);
        end
        $display("test_reset: outputs checked during and after reset");
    endtask

    task automatic test_directed();
        logic [W-1:0] av [3] = '{8'h5A, 8'h00, 8'h80};
        logic [W-1:0] bv [3] = '{8'h3C, 8'h01, 8'hFF};
        logic [W-1:0] ed [3] = '{8'h1E, 8'hFF, 8'h81};
        logic         eb [3] = '{1'b0, 1'b1, 1'b1};
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        int           bc;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], d, bo, lat, bc);
            checks++;
            if (lat !== W || bc !== W) begin
                errors++;
                $display("FAIL directed_timing: a=%h b=%h got done_at=%0d busy_cycles=%0d, want %0d/%0d",
                         av[i], bv[i], lat, bc, W, W);
            end
            checks++;
            if (d !== ed[i] || bo !== eb[i]) begin
                errors++;
                $display("FAIL directed_result: a=%h b=%h got diff=%h bout=%b, want diff=%h bout=%b",
                         av[i], bv[i], d, bo, ed[i], eb[i]);
            end
            $display("directed: a=%h b=%h diff=%h bout=%b done_at=%0d", av[i], bv[i], d, bo, lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        int           bc;
        int           ref_d;
        for (int i = 0; i < 24; i++) begin
            av = W'($urandom);
            bv = W'($urandom);
            if (i == 0) bv = av;
            do_op(av, bv, d, bo, lat, bc);
            ref_d = (int'(av) - int'(bv) + (1 << W)) % (1 << W);
            checks++;
            if (lat !== W || d !== W'(ref_d) || bo !== (av < bv)) begin
                errors++;
                $display("FAIL random_op: a=%h b=%h got diff=%h bout=%b done_at=%0d, want diff=%h bout=%b done_at=%0d",
                         av, bv, d, bo, lat, W'(ref_d), (av < bv), W);
            end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            checks++;
            if (bus.zero !== (ref_d == 0)) begin
                errors++;
                $display("FAIL random_zero: a=%h b=%h got zero=%b, want %b", av, bv, bus.zero, (ref_d == 0));
            end
`endif
            $display("random: a=%h b=%h diff=%h bout=%b", av, bv, d, bo);
        end
    endtask

    task automatic test_start_held();
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] d;
        logic         bo;
        int           dones;
        a0 = W'($urandom);
        b0 = W'($urandom);
        d  = '0;
        bo = 1'b0;
        @(negedge clk);
        bus.a     = a0;
        bus.b     = b0;
        bus.start = 1'b1;
        dones     = 0;
        for (int c = 0; c < 3 * W; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                d  = bus.diff;
                bo = bus.bout;
                bus.start = 1'b0;
            end else if (bus.start) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
            end
        end
        checks++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL held_done_count: got %0d done pulses, want 1", dones);
        end
        checks++;
        if (d !== W'(a0 - b0) || bo !== (a0 < b0)) begin
            errors++;
            $display("FAIL held_result: a=%h b=%h got diff=%h bout=%b, want diff=%h bout=%b",
                     a0, b0, d, bo, W'(a0 - b0), (a0 < b0));
        end
        $display("start_held: a=%h b=%h dones=%0d diff=%h", a0, b0, dones, d);
    endtask

    task automatic test_abort();
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        int           bc;
        int           stray;
        @(negedge clk);
        bus.a     = 8'hC3;
        bus.b     = 8'h5E;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.diff, bus.bout} !== '0) begin
            errors++;
            $display("FAIL abort_async: got busy=%b done=%b diff=%h bout=%b, want all 0",
                     bus.busy, bus.done, bus.diff, bus.bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d cycles with busy/done, want 0", stray);
        end
        do_op(8'h27, 8'h9C, d, bo, lat, bc);
        checks++;
        if (lat !== W || d !== 8'h8B || bo !== 1'b1) begin
            errors++;
            $display("FAIL abort_recover: got diff=%h bout=%b done_at=%0d, want diff=8b bout=1 done_at=%0d",
                     d, bo, lat, W);
        end
        $display("abort: post-reset op diff=%h bout=%b", d, bo);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d;
        logic         bo;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        int           lat;
        int           bc;
        do_op(8'h10, 8'h01, d, bo, lat, bc);
        a1 = W'($urandom);
        b1 = W'($urandom);
        bus.a     = a1;
        bus.b     = b1;
        bus.start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_ignored: got busy=%b after start in DONE, want 0", bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_accept: got busy=%b after start in IDLE, want 1", bus.busy);
        end
        lat = -1;
        for (int c = 0; c < W + 6; c++) begin
            if (bus.done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat !== W || bus.diff !== W'(a1 - b1) || bus.bout !== (a1 < b1)) begin
            errors++;
            $display("FAIL b2b_result: a=%h b=%h got diff=%h bout=%b done_at=%0d, want diff=%h bout=%b done_at=%0d",
                     a1, b1, bus.diff, bus.bout, lat, W'(a1 - b1), (a1 < b1), W);
        end
        $display("back_to_back: a=%h b=%h diff=%h bout=%b", a1, b1, bus.diff, bus.bout);
    endtask

    task automatic test_width1();
        @(negedge clk);
        bus1.a     = 1'b0;
        bus1.b     = 1'b1;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        checks++;
        if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
            errors++;
            $display("FAIL w1_run: got busy=%b done=%b, want busy=1 done=0", bus1.busy, bus1.done);
        end
        @(negedge clk);
        checks++;
        if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || bus1.diff !== 1'b1 || bus1.bout !== 1'b1) begin
            errors++;
            $display("FAIL w1_result: got done=%b busy=%b diff=%b bout=%b, want 1 0 1 1",
                     bus1.done, bus1.busy, bus1.diff, bus1.bout);
        end
        $display("width1: a=0 b=1 diff=%b bout=%b", bus1.diff, bus1.bout);
    endtask

`ifdef SERIAL_SUB_ZERO_FLAG_EN
    task automatic test_zero_flag();
        logic [W-1:0] d;
        logic         bo;
        int           lat;
        int           bc;
        do_op(8'hFF, 8'hFF, d, bo, lat, bc);
        checks++;
        if (d !== 8'h00 || bo !== 1'b0 || bus.zero !== 1'b1) begin
            errors++;
            $display("FAIL zero_set: got diff=%h bout=%b zero=%b, want 00 0 1", d, bo, bus.zero);
        end
        do_op(8'h02, 8'h01, d, bo, lat, bc);
        checks++;
        if (d !== 8'h01 || bus.zero !== 1'b0) begin
            errors++;
            $display("FAIL zero_clear: got diff=%h zero=%b, want 01 0", d, bus.zero);
        end
        $display("zero_flag: last diff=%h zero=%b", d, bus.zero);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_abort();
        test_back_to_back();
        test_width1();
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
